// File: rtl/bitvault_pkg.sv
// Shared constants and types for the bitvault register-file host controller.
// Optional write retry is enabled with the BITVAULT_RETRY_EN macro.
package bitvault_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 2;
    localparam int MAX_RETRY_DEF = 2;

    localparam int ERR_CNT_W   = 8;
    localparam int ERR_CNT_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/bitvault_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
// Used for the error counter and, with BITVAULT_RETRY_EN, the retry counter.
module bitvault_sat_cnt #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] C_MAX = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bitvault_host.sv
// Initiator for the bitvault register file: one request at a time, every write
// is read back and verified. Define BITVAULT_RETRY_EN to re-attempt failed writes.
module bitvault_host
    import bitvault_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]    rf_data_in,
    input  logic [DATA_W-1:0]    rf_data_out
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic w_req_fire;
    logic w_rsp_fire;
    logic w_mismatch;
    logic w_retry;

    assign w_req_fire = req_valid && (r_state == ST_IDLE);
    assign w_rsp_fire = rsp_ready && (r_state == ST_RESP);
    assign w_mismatch = r_write && (rf_data_out != r_wdata);

`ifdef BITVAULT_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RW-1:0] w_retry_cnt;

    // Counter clears on the response handshake, i.e. on entry to IDLE.
    bitvault_sat_cnt #(
        .W   (RW),
        .MAX (MAX_RETRY)
    ) u_retry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_rsp_fire),
        .i_inc ((r_state == ST_VERIFY) && w_retry),
        .o_cnt (w_retry_cnt)
    );

    assign w_retry = w_mismatch && (w_retry_cnt != RW'(MAX_RETRY));
`else
    // Constant 0: with retries compiled out a mismatch always terminates.
    assign w_retry = (MAX_RETRY < 0);
`endif

    bitvault_sat_cnt #(
        .W   (ERR_CNT_W),
        .MAX (ERR_CNT_MAX)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (w_rsp_fire && r_err),
        .o_cnt (err_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_next = req_write ? ST_WRITE : ST_VERIFY;
            ST_WRITE:  w_state_next = ST_VERIFY;
            ST_VERIFY: w_state_next = w_retry ? ST_WRITE : ST_RESP;
            ST_RESP:   if (rsp_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if ((r_state == ST_VERIFY) && !w_retry) begin
                r_rdata <= rf_data_out;
                r_err   <= w_mismatch;
            end
        end
    end

    // Outputs depend only on registered state and holding registers.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        rf_we      = (r_state == ST_WRITE);
        rsp_valid  = (r_state == ST_RESP);
        rf_addr    = r_addr;
        rf_data_in = r_wdata;
        rsp_rdata  = r_rdata;
        rsp_err    = r_err;
    end

endmodule

// File: tb/tb_bitvault_host.sv
// Self-checking bench for bitvault_host against a 4x8 register file model with
// stuck-bit faults; build with BITVAULT_RETRY_EN to check the retry variant.
module tb_bitvault_host;

    localparam int MR = 2;
`ifdef BITVAULT_RETRY_EN
    localparam int RETRIES = MR;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [1:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] err_cnt;
    logic       rf_we;
    logic [1:0] rf_addr;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out;

    always #5 clk = ~clk;

    bitvault_host #(
        .DATA_W    (8),
        .ADDR_W    (2),
        .MAX_RETRY (MR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .err_cnt     (err_cnt),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    // Register file model: raw storage plus per-address stuck-at-0/1 masks on read.
    logic [7:0] mem [4];
    logic [7:0] s0  [4];
    logic [7:0] s1  [4];
    int         we_total = 0;

    assign rf_data_out = (mem[rf_addr] & ~s0[rf_addr]) | s1[rf_addr];

    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            mem[rf_addr] <= rf_data_in;
            we_total     <= we_total + 1;
        end
    end

    // Reference state kept by the bench.
    logic [7:0] ref_mem [4];
    int         exp_err_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit w, input logic [1:0] a, input logic [7:0] d, input bit consume,
                       output logic [7:0] rd, output logic er, output int lat, output int pulses);
        int n;
        int we0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", 32'(n < 50), 32'd1);
        we0 = we_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pulses = we_total - we0;
        rd = rsp_rdata;
        er = rsp_err;
        if (consume) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input bit w, input logic [1:0] a, input logic [7:0] d, input bit consume);
        logic [7:0] e_rd;
        logic [7:0] rd;
        logic       e_er;
        logic       er;
        int         e_lat;
        int         lat;
        int         e_pl;
        int         pl;
        if (w) ref_mem[a] = d;
        e_rd  = (ref_mem[a] & ~s0[a]) | s1[a];
        e_er  = w && (e_rd != d);
        e_lat = !w ? 2 : (e_er ? 3 + 2 * RETRIES : 3);
        e_pl  = !w ? 0 : (e_er ? 1 + RETRIES : 1);
        txn(w, a, d, consume, rd, er, lat, pl);
        $display("txn %s addr=%0d wdata=0x%02h rdata=0x%02h err=%0d lat=%0d we_pulses=%0d",
                 w ? "WR" : "RD", a, d, rd, er, lat, pl);
        check("rsp_rdata", 32'(rd), 32'(e_rd));
        check("rsp_err", 32'(er), 32'(e_er));
        check("latency", 32'(lat), 32'(e_lat));
        check("we_pulses", 32'(pl), 32'(e_pl));
        if (consume) begin
            if (e_er && exp_err_cnt < 255) exp_err_cnt++;
            check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 4; i++) begin
            s0[i] = 8'h00;
            s1[i] = 8'h00;
        end

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_data_in", 32'(rf_data_in), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Directed writes then reads of all addresses
        step(1'b1, 2'd0, 8'hAA, 1'b1);
        step(1'b1, 2'd1, 8'h55, 1'b1);
        step(1'b1, 2'd2, 8'hF0, 1'b1);
        step(1'b1, 2'd3, 8'h0F, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 8'h00, 1'b1);

        // Stuck-at-0 on bit 7 of address 1: 0x99 reads back as 0x19
        s0[1] = 8'h80;
        step(1'b1, 2'd1, 8'h99, 1'b1);
        check("fault_rdata_literal", 32'(rsp_rdata), 32'h19);
        s0[1] = 8'h00;

        // Response back-pressure with a competing request
        rsp_ready = 1'b0;
        step(1'b1, 2'd3, 8'h3C, 1'b0);
        held = rsp_rdata;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", 32'(rsp_rdata), 32'(held));
            check("hold_rsp_err", 32'(rsp_err), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hold_idle", 32'(req_ready), 32'd1);
        check("after_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        step(1'b0, 2'd0, 8'h00, 1'b1);

        // Asynchronous reset during the WRITE cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd2;
        req_wdata = 8'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("midwrite_we_high", 32'(rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midwrite_we_dropped", 32'(rf_we), 32'd0);
        check("midwrite_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err_cnt = 0;
        repeat (2) @(negedge clk);
        check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        check("post_reset_err_cnt", 32'(err_cnt), 32'd0);
        step(1'b0, 2'd2, 8'h00, 1'b1);
        check("prewrite_value_kept", 32'(rsp_rdata), 32'hF0);

        // Randomized traffic with occasional stuck bits
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                for (int k = 0; k < 4; k++) begin
                    s0[k] = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                    s1[k] = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                end
            end
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            s0[k] = 8'h00;
            s1[k] = 8'h00;
        end

        // Error counter saturation: bit 0 of address 0 stuck at 1, write even values
        s1[0] = 8'h01;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 2'd0, 8'($urandom) & 8'hFE, 1'b1);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        s1[0] = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
